alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Sequential front end for the combinational ALUunit. Sits between register-read and writeback.
- Accepts one RV32I OP or OP-IMM instruction with its register operands over a valid/ready handshake.
- Decodes the instruction to the 4-bit ALU opcode, drives the registered operands, samples the ALU result, and presents it to writeback over a second valid/ready handshake.

Parameters:
- RESULT_LATENCY, 1, cycles after the operands become visible on alu_*_out at which alu_result_in is sampled (range 1-7).
- COUNT_W, 16, width of the retired-operation counter.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  synchronous, active-high reset.
- issue_valid_in  input  1  instruction/operands valid.
- issue_ready_out  output  1  block can accept an instruction.
- instr_in  input  32  RV32I instruction word.
- rs1_data_in  input  32  rs1 register value.
- rs2_data_in  input  32  rs2 register value.
- alu_op1_out  output  32  to ALU op1_in.
- alu_op2_out  output  32  to ALU op2_in.
- alu_opcode_out  output  4  to ALU opcode_in.
- alu_result_in  input  32  from ALU result_out.
- wb_valid_out  output  1  writeback data valid.
- wb_ready_in  input  1  writeback accepts.
- wb_data_out  output  32  captured result.
- wb_rd_out  output  5  destination register.
- illegal_out  output  1  one-cycle pulse: rejected instruction.
- ops_count_out  output  COUNT_W  retired operations, wraps.

Behaviour:
- Reset: one clock, synchronous, active-high; the clock is clk_in and the reset is rst_in.
  - All outputs are 0 while rst_in is high, including issue_ready_out. State returns to IDLE and the wait counter clears.
  - Reset mid-EXEC or mid-WB aborts the operation; no writeback is issued.
- FSM states: IDLE, EXEC, WB. issue_ready_out = 1 only in IDLE.
- Decode, done on the accepting edge:
  - opc = instr[6:0]; f3 = instr[14:12]; f7 = instr[31:25].
  - OP (0110011):
    - f7 = 0000000: alu_opcode = {0, f3}.
    - f7 = 0100000 with f3 = 000: alu_opcode = 1000 (SUB).
    - f7 = 0100000 with f3 = 101: alu_opcode = 1101 (SRA).
    - op1 = rs1; op2 = rs2, except shifts (f3 = 001/101) use op2 = {27'b0, rs2[4:0]}.
  - OP-IMM (0010011): alu_opcode = {0, f3}, except f3 = 101 with f7 = 0100000 gives 1101 (SRAI).
    - op2 for non-shifts = sign-extended instr[31:20].
    - op2 for shifts = {27'b0, instr[24:20]}.
    - Shifts require f7 = 0000000, or 0100000 for SRAI.
  - Any other opcode or f7 combination is illegal.
- IDLE:
  - On issue_valid_in & issue_ready_out with a legal instruction: register op1, op2, opcode and rd; load the wait counter with RESULT_LATENCY; go to EXEC.
  - If the instruction is illegal: stay IDLE, pulse illegal_out in the next cycle, leave the alu_* outputs unchanged.
- EXEC:
  - alu_* outputs are held stable; the counter decrements each cycle.
  - In the cycle the counter reads 1, alu_result_in is registered into wb_data_out and the state goes to WB.
  - Timing for RESULT_LATENCY = 1: accept edge at cycle N, operands visible in N+1, sample at the end of N+1, wb_valid_out = 1 from N+2.
- WB:
  - wb_valid_out = 1; wb_data_out and wb_rd_out are held stable until wb_ready_in.
  - On the handshake: ops_count_out increments (wrapping modulo 2^COUNT_W), next state IDLE, wb_valid_out drops in the next cycle.
  - rd = 0 is still executed and written back; the writeback stage discards it.
- Outside EXEC the alu_* outputs retain their last values.
- Minimum issue interval: RESULT_LATENCY + 2 cycles.
- issue_valid_in outside IDLE is ignored; the source holds it.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1 = 5, rs2 = 7, bench ALU model, wb_ready = 1 -> opcode 0000 and op1/op2 = 5/7 in N+1; wb_valid in N+2 with data 12, rd 3; count = 1.
- SUB x4,x1,x2 (0x40208233), rs1 = 3, rs2 = 10 -> opcode 1000; wb_data 0xFFFFFFF9.
- SRAI x5,x6,4 (0x40435293), rs1 = 0x80000000 -> opcode 1101, op2 = 4; wb_data 0xF8000000.
- SLL with rs2 = 0x25 -> op2 = 5. ADDI with imm = -1 -> op2 = 0xFFFFFFFF.
- ECALL (0x00000073), or OP with f7 = 0000001 -> illegal_out high for exactly one cycle, no wb_valid, issue_ready stays 1.
- wb_ready low for 3 cycles in WB -> wb_valid, data and rd stable, issue_ready 0.
- rst_in asserted in EXEC -> all outputs 0 next cycle, no writeback.
- With COUNT_W = 4, 17 retired ops -> count = 1.
- With RESULT_LATENCY = 3 -> wb_valid first asserts in N+4.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequential front end for the combinational ALU.
// Accepts one RV32I OP / OP-IMM instruction with its operands, decodes it to
// the 4-bit ALU opcode, drives registered operands, samples the ALU result
// RESULT_LATENCY cycles later and presents it to writeback.
// Ports:
//   clk_in, rst_in                      clock, synchronous active-high reset
//   issue_valid_in / issue_ready_out    instruction handshake
//   instr_in, rs1_data_in, rs2_data_in  instruction word and register operands
//   alu_op1_out, alu_op2_out,
//   alu_opcode_out, alu_result_in       ALU interface
//   wb_valid_out / wb_ready_in          writeback handshake
//   wb_data_out, wb_rd_out              captured result and destination
//   illegal_out                         one-cycle pulse on rejected instruction
//   ops_count_out                       retired-operation counter (wraps)
module alu_issue_ctrl #(
    parameter int unsigned RESULT_LATENCY = 1,
    parameter int unsigned COUNT_W        = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               issue_valid_in,
    output logic               issue_ready_out,
    input  logic [31:0]        instr_in,
    input  logic [31:0]        rs1_data_in,
    input  logic [31:0]        rs2_data_in,
    output logic [31:0]        alu_op1_out,
    output logic [31:0]        alu_op2_out,
    output logic [3:0]         alu_opcode_out,
    input  logic [31:0]        alu_result_in,
    output logic               wb_valid_out,
    input  logic               wb_ready_in,
    output logic [31:0]        wb_data_out,
    output logic [4:0]         wb_rd_out,
    output logic               illegal_out,
    output logic [COUNT_W-1:0] ops_count_out
);

    localparam int unsigned CNT_W = 3;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic [31:0]          op1_q, op1_d;
    logic [31:0]          op2_q, op2_d;
    logic [3:0]           opcode_q, opcode_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [31:0]          wb_data_q, wb_data_d;
    logic [4:0]           rd_q, rd_d;
    logic                 illegal_q, illegal_d;
    logic [COUNT_W-1:0]   count_q, count_d;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        is_shift;
    logic        dec_legal;
    logic [3:0]  dec_opcode;
    logic [31:0] dec_op2;

    // rs1/rs2 index fields are resolved upstream by register-read
    logic unused_fields;
    assign unused_fields = ^instr_in[19:15];

    assign opc      = instr_in[6:0];
    assign f3       = instr_in[14:12];
    assign f7       = instr_in[31:25];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    // Instruction decode to ALU opcode, second operand and legality
    always_comb begin
        dec_legal  = 1'b0;
        dec_opcode = {1'b0, f3};
        dec_op2    = rs2_data_in;
        case (opc)
            OPC_OP: begin
                if (is_shift) begin
                    dec_op2 = {27'b0, rs2_data_in[4:0]};
                end
                if (f7 == F7_ZERO) begin
                    dec_legal = 1'b1;
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    dec_legal  = 1'b1;
                    dec_opcode = 4'b1000;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    dec_legal  = 1'b1;
                    dec_opcode = 4'b1101;
                end
            end
            OPC_OP_IMM: begin
                if (is_shift) begin
                    // f7 overlaps the immediate; only shifts constrain it
                    dec_op2 = {27'b0, instr_in[24:20]};
                    if (f7 == F7_ZERO) begin
                        dec_legal = 1'b1;
                    end else if (f7 == F7_ALT && f3 == 3'b101) begin
                        dec_legal  = 1'b1;
                        dec_opcode = 4'b1101;
                    end
                end else begin
                    dec_op2   = {{20{instr_in[31]}}, instr_in[31:20]};
                    dec_legal = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        opcode_d   = opcode_q;
        wb_valid_d = wb_valid_q;
        wb_data_d  = wb_data_q;
        rd_d       = rd_q;
        illegal_d  = 1'b0;
        count_d    = count_q;
        case (state_q)
            S_IDLE: begin
                if (issue_valid_in && ready_q) begin
                    if (dec_legal) begin
                        op1_d    = rs1_data_in;
                        op2_d    = dec_op2;
                        opcode_d = dec_opcode;
                        rd_d     = instr_in[11:7];
                        cnt_d    = CNT_W'(RESULT_LATENCY);
                        state_d  = S_EXEC;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    wb_data_d  = alu_result_in;
                    wb_valid_d = 1'b1;
                    state_d    = S_WB;
                end
            end
            S_WB: begin
                if (wb_ready_in) begin
                    wb_valid_d = 1'b0;
                    count_d    = count_q + COUNT_W'(1);
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // State register; reset clears every output including ready
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            op1_q      <= '0;
            op2_q      <= '0;
            opcode_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            rd_q       <= '0;
            illegal_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            opcode_q   <= opcode_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            rd_q       <= rd_d;
            illegal_q  <= illegal_d;
            count_q    <= count_d;
        end
    end

    assign issue_ready_out = ready_q;
    assign alu_op1_out     = op1_q;
    assign alu_op2_out     = op2_q;
    assign alu_opcode_out  = opcode_q;
    assign wb_valid_out    = wb_valid_q;
    assign wb_data_out     = wb_data_q;
    assign wb_rd_out       = rd_q;
    assign illegal_out     = illegal_q;
    assign ops_count_out   = count_q;

endmodule
